// File: rtl/snoop_responder_pkg.sv
// Shared encodings and types for the L2 snoop responder: bus ops, MESI,
// L1 messages, snoop results, FSM states and the request/action records.
package snoop_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 15;
  localparam int OFF_W  = 6;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int NWAYS  = 8;

  localparam logic [2:0] BREAD  = 3'd1;
  localparam logic [2:0] BWRITE = 3'd2;
  localparam logic [2:0] BINVAL = 3'd3;
  localparam logic [2:0] BRWIM  = 3'd4;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_E = 2'd1;
  localparam logic [1:0] MESI_S = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  localparam logic [2:0] GETLINE   = 3'd1;
  localparam logic [2:0] SENDLINE  = 3'd2;
  localparam logic [2:0] INVALLINE = 3'd3;
  localparam logic [2:0] EVICTLINE = 3'd4;

  localparam logic [1:0] HIT   = 2'd0;
  localparam logic [1:0] HITM  = 2'd1;
  localparam logic [1:0] NOHIT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_DECIDE, ST_L1_GET, ST_WB, ST_L1_INV, ST_FINISH
  } snp_fsm_e;

  typedef struct packed {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
  } snp_req_t;

  typedef struct packed {
    logic [1:0] rslt;
    logic [1:0] new_state;
    logic       need_get;
    logic       need_wb;
    logic       need_inv;
    logic       err;
  } snp_act_t;

endpackage

// File: rtl/snoop_responder_if.sv
// Snoop responder bus bundle: snoop request, tag lookup/update, result,
// L1 message channel, write-back channel, error and statistics.
interface snoop_responder_if
  import snoop_responder_pkg::*;
#(
  parameter int I_SIZE     = ADDR_W,
  parameter int INDEX_BITS = IDX_W,
  parameter int TAG_BITS   = TAG_W,
  parameter int WAYS       = NWAYS
);
  localparam int WAY_BITS = $clog2(WAYS);

  logic                  snp_valid, snp_ready;
  logic [2:0]            snp_op;
  logic [I_SIZE-1:0]     snp_addr;
  logic                  lk_req, lk_ack, lk_hit;
  logic [INDEX_BITS-1:0] lk_index;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [WAY_BITS-1:0]   lk_way;
  logic [1:0]            lk_state;
  logic                  upd_en;
  logic [INDEX_BITS-1:0] upd_index;
  logic [WAY_BITS-1:0]   upd_way;
  logic [1:0]            upd_state;
  logic                  rslt_valid;
  logic [1:0]            rslt;
  logic                  l1_msg_valid, l1_msg_ack;
  logic [2:0]            l1_msg;
  logic                  wb_valid, wb_ready;
  logic [I_SIZE-1:0]     wb_addr;
  logic                  protocol_err;
  logic [31:0]           hit_cnt, hitm_cnt, miss_cnt;

  // Responder side
  modport slave (
    input  snp_valid, snp_op, snp_addr, lk_ack, lk_hit, lk_way, lk_state,
           l1_msg_ack, wb_ready,
    output snp_ready, lk_req, lk_index, lk_tag, upd_en, upd_index, upd_way,
           upd_state, rslt_valid, rslt, l1_msg_valid, l1_msg, wb_valid,
           wb_addr, protocol_err, hit_cnt, hitm_cnt, miss_cnt
  );

  // Bus / tag array / L1 side
  modport master (
    output snp_valid, snp_op, snp_addr, lk_ack, lk_hit, lk_way, lk_state,
           l1_msg_ack, wb_ready,
    input  snp_ready, lk_req, lk_index, lk_tag, upd_en, upd_index, upd_way,
           upd_state, rslt_valid, rslt, l1_msg_valid, l1_msg, wb_valid,
           wb_addr, protocol_err, hit_cnt, hitm_cnt, miss_cnt
  );
endinterface

// File: rtl/snoop_action_lut.sv
// Combinational snoop decision table: (bus op, current MESI) -> result,
// next MESI, required L1/write-back work and protocol error flag.
module snoop_action_lut
  import snoop_responder_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] state,
  output snp_act_t   act
);
  always_comb begin
    act           = '0;
    act.rslt      = NOHIT;
    act.new_state = state;
    // A line in I never responds, whatever the op
    if (state != MESI_I) begin
      case (op)
        BREAD: begin
          act.new_state = MESI_S;
          if (state == MESI_M) begin
            act.rslt     = HITM;
            act.need_get = 1'b1;
            act.need_wb  = 1'b1;
          end else begin
            act.rslt = HIT;
          end
        end
        BRWIM: begin
          act.new_state = MESI_I;
          act.need_inv  = 1'b1;
          if (state == MESI_M) begin
            act.rslt     = HITM;
            act.need_get = 1'b1;
            act.need_wb  = 1'b1;
          end else begin
            act.rslt = HIT;
          end
        end
        BINVAL: begin
          if (state == MESI_S) begin
            act.rslt      = HIT;
            act.new_state = MESI_I;
            act.need_inv  = 1'b1;
          end else begin
            act.err = 1'b1;
          end
        end
        BWRITE:  act.err = 1'b1;
        default: act.err = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/snoop_responder.sv
// L2 snoop responder: looks up snooped lines, answers HIT/HITM/NOHIT, drives
// L1 messages and write-backs, applies MESI updates. SNOOP_STATS_EN adds counters.
module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int I_SIZE     = ADDR_W,
  parameter int INDEX_BITS = IDX_W,
  parameter int TAG_BITS   = TAG_W,
  parameter int WAYS       = NWAYS
)(
  input logic           clk,
  input logic           rst_n,
  snoop_responder_if.slave bus
);
  localparam int OFF_BITS = I_SIZE - INDEX_BITS - TAG_BITS;

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] LOOKUP = ST_LOOKUP;
  localparam logic [2:0] DECIDE = ST_DECIDE;
  localparam logic [2:0] L1_GET = ST_L1_GET;
  localparam logic [2:0] WB     = ST_WB;
  localparam logic [2:0] L1_INV = ST_L1_INV;
  localparam logic [2:0] FINISH = ST_FINISH;

  logic [2:0]               state, state_nx;
  snp_req_t                 req;
  logic [$clog2(WAYS)-1:0]  way_q;
  logic [1:0]               mesi_q;
  snp_act_t                 act;
  logic                     fin;
  logic                     unused_off;

  assign unused_off = ^bus.snp_addr[OFF_BITS-1:0];

  snoop_action_lut u_lut (
    .op    (req.op),
    .state (mesi_q),
    .act   (act)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.snp_valid) state_nx = LOOKUP;
      LOOKUP:  if (bus.lk_ack) state_nx = DECIDE;
      DECIDE:  state_nx = act.need_get ? L1_GET : (act.need_inv ? L1_INV : FINISH);
      L1_GET:  if (bus.l1_msg_ack) state_nx = act.need_wb ? WB : (act.need_inv ? L1_INV : FINISH);
      WB:      if (bus.wb_ready) state_nx = act.need_inv ? L1_INV : FINISH;
      L1_INV:  if (bus.l1_msg_ack) state_nx = FINISH;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req    <= '0;
      way_q  <= '0;
      mesi_q <= MESI_I;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.snp_valid) begin
        req.op    <= bus.snp_op;
        req.tag   <= bus.snp_addr[I_SIZE-1 -: TAG_BITS];
        req.index <= bus.snp_addr[OFF_BITS +: INDEX_BITS];
      end
      // A tag miss behaves exactly like a line held in I
      if (state == LOOKUP && bus.lk_ack) begin
        way_q  <= bus.lk_way;
        mesi_q <= bus.lk_hit ? bus.lk_state : MESI_I;
      end
    end
  end

  // Moore outputs: every strobe drops the moment reset forces IDLE
  assign fin              = (state == FINISH);
  assign bus.snp_ready    = (state == IDLE);
  assign bus.lk_req       = (state == LOOKUP);
  assign bus.lk_index     = bus.lk_req ? req.index : '0;
  assign bus.lk_tag       = bus.lk_req ? req.tag : '0;
  assign bus.upd_en       = fin && (act.new_state != mesi_q);
  assign bus.upd_index    = bus.upd_en ? req.index : '0;
  assign bus.upd_way      = bus.upd_en ? way_q : '0;
  assign bus.upd_state    = bus.upd_en ? act.new_state : '0;
  assign bus.rslt_valid   = fin;
  assign bus.rslt         = fin ? act.rslt : '0;
  assign bus.protocol_err = fin && act.err;
  assign bus.l1_msg_valid = (state == L1_GET) || (state == L1_INV);
  assign bus.l1_msg       = (state == L1_GET) ? GETLINE :
                            (state == L1_INV) ? INVALLINE : 3'd0;
  assign bus.wb_valid     = (state == WB);
  assign bus.wb_addr      = bus.wb_valid ? {req.tag, req.index, {OFF_BITS{1'b0}}} : '0;

`ifdef SNOOP_STATS_EN
  logic [31:0] hit_q, hitm_q, miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      hitm_q <= '0;
      miss_q <= '0;
    end else if (fin) begin
      if (act.rslt == HIT   && hit_q  != '1) hit_q  <= hit_q + 32'd1;
      if (act.rslt == HITM  && hitm_q != '1) hitm_q <= hitm_q + 32'd1;
      if (act.rslt == NOHIT && miss_q != '1) miss_q <= miss_q + 32'd1;
    end
  end

  assign bus.hit_cnt  = hit_q;
  assign bus.hitm_cnt = hitm_q;
  assign bus.miss_cnt = miss_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.hitm_cnt = '0;
  assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Directed + random bench for snoop_responder against a rule-level snoop model.
module tb_snoop_responder;
  import snoop_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_responder_if bus();
  snoop_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int e_hit = 0, e_hitm = 0, e_miss = 0;

  localparam logic [3:0] EV_WB = 4'd8;

  typedef struct {
    logic [1:0]  rslt;
    logic [1:0]  nst;
    logic        upd;
    logic        err;
    logic [31:0] seq;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // What a snooping L2 must do, stated as a list of bus/L1 actions per op
  function automatic exp_t model(input logic [2:0] op, input logic hit, input logic [1:0] st);
    exp_t e;
    logic [1:0] m;
    bit owns, dirty;
    m     = hit ? st : MESI_I;
    owns  = (m != MESI_I);
    dirty = (m == MESI_M);
    e.rslt = NOHIT; e.nst = m; e.err = 1'b0; e.seq = '0;
    if (op == BREAD && owns) begin
      e.rslt = dirty ? HITM : HIT;
      e.nst  = MESI_S;
      if (dirty) e.seq = {24'd0, 1'b0, GETLINE, EV_WB};
    end else if (op == BRWIM && owns) begin
      e.rslt = dirty ? HITM : HIT;
      e.nst  = MESI_I;
      e.seq  = dirty ? {20'd0, 1'b0, GETLINE, EV_WB, 1'b0, INVALLINE}
                     : {28'd0, 1'b0, INVALLINE};
    end else if (op == BINVAL && owns) begin
      if (m == MESI_S) begin
        e.rslt = HIT; e.nst = MESI_I; e.seq = {28'd0, 1'b0, INVALLINE};
      end else begin
        e.err = 1'b1;
      end
    end else if (op == BWRITE) begin
      e.err = owns;
    end
    e.upd = (e.nst != m);
    return e;
  endfunction

  task automatic chk_stats();
`ifdef SNOOP_STATS_EN
    chk("hit_cnt", bus.hit_cnt, e_hit);
    chk("hitm_cnt", bus.hitm_cnt, e_hitm);
    chk("miss_cnt", bus.miss_cnt, e_miss);
`else
    chk("hit_cnt", bus.hit_cnt, 0);
    chk("hitm_cnt", bus.hitm_cnt, 0);
    chk("miss_cnt", bus.miss_cnt, 0);
`endif
  endtask

  task automatic do_snoop(input logic [2:0] op, input logic [31:0] addr, input logic hit,
                          input logic [1:0] st, input logic [2:0] way,
                          input int dl, input int dg, input int dw, input int di,
                          input bit rst_wb);
    exp_t e;
    int cyc = 0, rcyc = -1, n_lk = 0, n_msg = 0, n_wb = 0, wb_hold = 0;
    int upds = 0, errs = 0, lat;
    logic [31:0] seq = '0, got_wba = '0;
    logic [2:0]  prev_msg = '0, u_way = '0;
    logic [1:0]  got_rslt = '0, u_state = '0;
    logic [IDX_W-1:0] u_idx = '0;
    logic [3:0]  ev;
    bit unstable = 0, done = 0;
    e = model(op, hit, st);
    lat = 3 + dl;
    for (int k = 0; k < 8; k++) begin
      ev = e.seq[4*k +: 4];
      if (ev == {1'b0, GETLINE})   lat += 1 + dg;
      if (ev == {1'b0, INVALLINE}) lat += 1 + di;
      if (ev == EV_WB)             lat += 1 + dw;
    end

    @(negedge clk);
    chk("idle_ready", bus.snp_ready, 1);
    bus.snp_valid = 1'b1; bus.snp_op = op; bus.snp_addr = addr;
    bus.lk_hit = hit; bus.lk_state = st; bus.lk_way = way;
    @(negedge clk);
    bus.snp_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      bus.lk_ack = 1'b0; bus.l1_msg_ack = 1'b0; bus.wb_ready = 1'b0;
      if (bus.lk_req) begin
        if (bus.lk_index !== addr[20:6] || bus.lk_tag !== addr[31:21]) unstable = 1;
        if (n_lk == dl) bus.lk_ack = 1'b1;
        n_lk++;
      end
      if (bus.l1_msg_valid) begin
        if (n_msg > 0 && bus.l1_msg !== prev_msg) unstable = 1;
        prev_msg = bus.l1_msg;
        if (n_msg == ((bus.l1_msg == GETLINE) ? dg : di)) begin
          bus.l1_msg_ack = 1'b1; seq = (seq << 4) | {29'd0, bus.l1_msg}; n_msg = 0;
        end else n_msg++;
      end
      if (bus.wb_valid) begin
        if (wb_hold > 0 && bus.wb_addr !== got_wba) unstable = 1;
        wb_hold++;
        got_wba = bus.wb_addr;
        if (rst_wb && wb_hold == 3) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_wb_valid", bus.wb_valid, 0);
          chk("rst_ready", bus.snp_ready, 1);
          chk("rst_rslt", bus.rslt_valid, 0);
          chk("rst_l1", bus.l1_msg_valid, 0);
          repeat (2) @(negedge clk);
          chk("rst_hold_rslt", bus.rslt_valid, 0);
          rst_n = 1'b1;
          e_hit = 0; e_hitm = 0; e_miss = 0;
          chk_stats();
          return;
        end
        if (n_wb == dw) begin
          bus.wb_ready = 1'b1; seq = (seq << 4) | {28'd0, EV_WB}; n_wb = 0;
        end else n_wb++;
      end
      if (bus.upd_en) begin
        upds++; u_state = bus.upd_state; u_way = bus.upd_way; u_idx = bus.upd_index;
      end
      if (bus.protocol_err) errs++;
      if (bus.rslt_valid) begin rcyc = cyc; got_rslt = bus.rslt; done = 1; end
      @(negedge clk);
      cyc++;
    end
    bus.lk_ack = 1'b0; bus.l1_msg_ack = 1'b0; bus.wb_ready = 1'b0;

    chk("completed", done, 1);
    chk("rslt", got_rslt, e.rslt);
    chk("latency", rcyc, lat);
    chk("events", seq, e.seq);
    chk("upd_cnt", upds, e.upd);
    if (e.upd) begin
      chk("upd_state", u_state, e.nst);
      chk("upd_way", u_way, way);
      chk("upd_index", u_idx, addr[20:6]);
    end
    chk("err_cnt", errs, e.err);
    if (e.seq[7:4] == EV_WB || e.seq[3:0] == EV_WB) begin
      chk("wb_addr", got_wba, {addr[31:6], 6'b0});
      chk("wb_hold", wb_hold, dw + 1);
    end
    chk("stable", unstable, 0);
    chk("ready_after", bus.snp_ready, 1);
    if (e.rslt == HIT)   e_hit++;
    if (e.rslt == HITM)  e_hitm++;
    if (e.rslt == NOHIT) e_miss++;
    chk_stats();
  endtask

  initial begin
    bus.snp_valid = 1'b0; bus.snp_op = '0; bus.snp_addr = '0;
    bus.lk_ack = 1'b0; bus.lk_hit = 1'b0; bus.lk_way = '0; bus.lk_state = '0;
    bus.l1_msg_ack = 1'b0; bus.wb_ready = 1'b0;
    #1;
    chk("reset_ready", bus.snp_ready, 1);
    chk("reset_lk_req", bus.lk_req, 0);
    chk("reset_rslt_valid", bus.rslt_valid, 0);
    chk("reset_upd_en", bus.upd_en, 0);
    chk("reset_l1_valid", bus.l1_msg_valid, 0);
    chk("reset_wb_valid", bus.wb_valid, 0);
    chk("reset_err", bus.protocol_err, 0);
    chk("reset_rslt", bus.rslt, 0);
    chk_stats();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_snoop(BREAD,  32'h0040_0040, 1, MESI_M, 3'd2, 0, 0, 0, 0, 0);
    do_snoop(BREAD,  32'h1234_5678, 1, MESI_E, 3'd5, 0, 0, 0, 0, 0);
    do_snoop(BRWIM,  32'hdead_beef, 1, MESI_M, 3'd7, 1, 0, 5, 0, 0);
    do_snoop(BINVAL, 32'h0000_1000, 1, MESI_E, 3'd1, 0, 0, 0, 0, 0);
    do_snoop(BWRITE, 32'h0fff_ffc0, 0, MESI_M, 3'd0, 2, 0, 0, 0, 0);
    do_snoop(BRWIM,  32'h8000_0040, 1, MESI_M, 3'd3, 0, 1, 20, 0, 1);

    // After reset: 3 HIT, 2 HITM, 4 NOHIT
    do_snoop(BREAD,  32'h0040_0040, 1, MESI_M, 3'd2, 0, 0, 0, 0, 0);
    do_snoop(BREAD,  32'h0100_0080, 1, MESI_E, 3'd4, 0, 0, 0, 0, 0);
    do_snoop(BRWIM,  32'h0200_00c0, 1, MESI_S, 3'd6, 0, 0, 0, 2, 0);
    do_snoop(BINVAL, 32'h0300_0100, 1, MESI_S, 3'd1, 1, 0, 0, 1, 0);
    do_snoop(BRWIM,  32'h0400_0140, 1, MESI_M, 3'd0, 0, 2, 1, 3, 0);
    do_snoop(BWRITE, 32'h0500_0180, 0, MESI_I, 3'd0, 0, 0, 0, 0, 0);
    do_snoop(BREAD,  32'h0600_01c0, 0, MESI_S, 3'd2, 0, 0, 0, 0, 0);
    do_snoop(BINVAL, 32'h0700_0200, 1, MESI_M, 3'd3, 0, 0, 0, 0, 0);
    do_snoop(BWRITE, 32'h0800_0240, 1, MESI_S, 3'd5, 0, 0, 0, 0, 0);
`ifdef SNOOP_STATS_EN
    chk("stat_hit3", bus.hit_cnt, 3);
    chk("stat_hitm2", bus.hitm_cnt, 2);
    chk("stat_miss4", bus.miss_cnt, 4);
`endif

    for (int i = 0; i < 40; i++) begin
      do_snoop(3'($urandom_range(1, 4)), $urandom, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
